// File: rtl/bp_sched_pkg.sv
// bp_sched_pkg: shared state enum, update-entry type and parameter defaults for bp_access_scheduler
package bp_sched_pkg;
  localparam int IP_W_DEF = 64;
  localparam int QDEPTH_DEF = 4;
  localparam int STARVE_LIM_DEF = 8;
  localparam int IP_W_MAX = 64;
  typedef enum logic {NORMAL, DRAIN} sched_state_t;
  typedef struct packed {
    logic [IP_W_MAX-1:0] ip;
    logic                taken;
  } upd_entry_t;
endpackage

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo: update queue in front of the predictor table, power-of-two depth
// Ports: clk, reset_n (async, active-low); push/din write the tail; pop retires head;
//        count is occupancy; full/empty are derived from count.
module bp_upd_fifo
  import bp_sched_pkg::*;
#(
  parameter int DEPTH = QDEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  upd_entry_t   din,
  output upd_entry_t   head,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);
  upd_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign head = mem[rd_ptr];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/bp_access_scheduler.sv
// bp_access_scheduler: arbitrates fetch lookups and queued updates onto a single-port predictor table
// Ports: clk, reset_n (async, active-low); lk_valid/lk_ip/lk_ready lookup request and grant;
//        lk_pred_valid/lk_pred registered prediction; upd_valid/upd_ip/upd_taken/upd_ready update push;
//        tbl_en/tbl_we/tbl_ip/tbl_taken/tbl_pred table access; q_count queue occupancy.
// Config: define BP_STARVE_GUARD_EN to force an update after STARVE_LIM lookups while updates wait.
module bp_access_scheduler
  import bp_sched_pkg::*;
#(
  parameter int IP_W = IP_W_DEF,
  parameter int QDEPTH = QDEPTH_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF,
  localparam int CW = $clog2(QDEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            lk_valid,
  input  logic [IP_W-1:0] lk_ip,
  output logic            lk_ready,
  output logic            lk_pred_valid,
  output logic            lk_pred,
  input  logic            upd_valid,
  input  logic [IP_W-1:0] upd_ip,
  input  logic            upd_taken,
  output logic            upd_ready,
  output logic            tbl_en,
  output logic            tbl_we,
  output logic [IP_W-1:0] tbl_ip,
  output logic            tbl_taken,
  input  logic            tbl_pred,
  output logic [CW-1:0]   q_count
);
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);
  localparam logic [CW-1:0] HALF_CNT = CW'(QDEPTH / 2);
  sched_state_t state, state_nxt;
  upd_entry_t push_entry, head;
  logic alive, push, full, empty, upd_grant, lk_grant, starved;
  logic [CW-1:0] cnt_nxt;
  // alive gates every grant so outputs drop the instant reset asserts and resume on the first edge after release
  assign upd_ready = alive && !full;
  assign push = upd_valid && upd_ready;
  assign cnt_nxt = q_count + CW'(push) - CW'(upd_grant);
  always_comb begin
    push_entry = '0;
    push_entry.ip[IP_W-1:0] = upd_ip;
    push_entry.taken = upd_taken;
  end
  bp_upd_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(upd_grant), .din(push_entry),
    .head(head), .count(q_count), .full(full), .empty(empty)
  );
  always_comb begin
    upd_grant = alive && !empty && (state == DRAIN || !lk_valid || starved);
    lk_grant = alive && state == NORMAL && lk_valid && !upd_grant;
    state_nxt = state == NORMAL ? (cnt_nxt == FULL_CNT ? DRAIN : NORMAL)
                                : (cnt_nxt <= HALF_CNT ? NORMAL : DRAIN);
  end
  assign lk_ready = lk_grant;
  assign tbl_en = upd_grant || lk_grant;
  assign tbl_we = upd_grant;
  assign tbl_ip = upd_grant ? head.ip[IP_W-1:0] : lk_grant ? lk_ip : '0;
  assign tbl_taken = upd_grant && head.taken;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= NORMAL;
      alive <= 1'b0;
      lk_pred_valid <= 1'b0;
      lk_pred <= 1'b0;
    end else begin
      state <= state_nxt;
      alive <= 1'b1;
      lk_pred_valid <= lk_grant;
      if (lk_grant) lk_pred <= tbl_pred;
    end
`ifdef BP_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);
  logic [SW-1:0] starve;
  assign starved = starve == LIM;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) starve <= '0;
    else if (upd_grant || empty) starve <= '0;
    else if (lk_grant && !starved) starve <= starve + 1'b1;
`else
  // without the guard updates wait for an idle lookup cycle or DRAIN; STARVE_LIM is inert
  assign starved = STARVE_LIM < 0;
`endif
endmodule
